// File: rtl/counter_run_control_pkg.sv
// Shared types and constants for the counter run/step control stage.
package counter_run_control_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    HELD_HIGH,
    WAIT_LOW
  } db_state_e;

  localparam int unsigned DIV_DEFAULT             = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 8;

  // Width needed to hold 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    longint unsigned span;
    width = 0;
    span  = 1;
    while (span < longint'(value)) begin
      span  = span << 1;
      width = width + 1;
    end
    if (width == 0) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/counter_run_control_button_debounce.sv
// Two-flop synchronizer plus level-change debounce FSM for one push button.
module button_debounce
  import counter_run_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic accept
);

  localparam int unsigned     CW       = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HELD_HIGH;
          cnt_d    = '0;
          accept_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = HELD_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe on the accepting edge; the parent registers it so run can toggle together with the press pulse.
  assign accept = accept_d;

endmodule

// File: rtl/counter_run_control.sv
// Run/stop and single-step control: debounced buttons, run state, tick prescaler.
module counter_run_control
  import counter_run_control_pkg::*;
#(
  parameter int unsigned DIV             = DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic input_clock1_1,
  input  logic input_reset_1,
  input  logic input_push_button_run,
  input  logic input_push_button_step,
  output logic output_tick,
  output logic output_run,
  output logic output_press_run,
  output logic output_press_step
);

  localparam int unsigned   PW         = clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic          run_accept, step_accept;
  logic          run_q, run_d;
  logic          press_run_q, press_step_q;
  logic [PW-1:0] presc_q, presc_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk     (input_clock1_1),
    .rst     (input_reset_1),
    .btn_raw (input_push_button_run),
    .accept  (run_accept)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (input_clock1_1),
    .rst     (input_reset_1),
    .btn_raw (input_push_button_step),
    .accept  (step_accept)
  );

  // Prescaler only counts while run is steady high; both run edges restart it at 0.
  always_comb begin
    run_d   = run_q ^ run_accept;
    presc_d = '0;
    if (run_q && run_d) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge input_clock1_1) begin
    if (input_reset_1) begin
      run_q        <= 1'b0;
      press_run_q  <= 1'b0;
      press_step_q <= 1'b0;
      presc_q      <= '0;
    end else begin
      run_q        <= run_d;
      press_run_q  <= run_accept;
      press_step_q <= step_accept;
      presc_q      <= presc_d;
    end
  end

  assign output_tick       = (run_q && (presc_q == PRESC_LAST)) || (!run_q && press_step_q);
  assign output_run        = run_q;
  assign output_press_run  = press_run_q;
  assign output_press_step = press_step_q;

endmodule

// File: tb/tb_counter_run_control.sv
// Scoreboard bench for counter_run_control: stimulus queues expected pulses, a monitor checks them.
module tb_counter_run_control;

  localparam int DIV = 4;
  localparam int DB  = 8;
  localparam int LAT = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic tick, run, pr, ps;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic tick;
    logic run;
    logic pr;
    logic ps;
  } ev_t;

  ev_t  sb[$];
  ev_t  lq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic done    = 1'b0;

  int bounce_on[5]  = '{1, 0, 1, 1, 0};
  int bounce_off[5] = '{0, 1, 0, 0, 1};

  counter_run_control #(.DIV(DIV), .DEBOUNCE_CYCLES(DB)) dut (
    .input_clock1_1         (clk),
    .input_reset_1          (rst),
    .input_push_button_run  (btn_run),
    .input_push_button_step (btn_step),
    .output_tick            (tick),
    .output_run             (run),
    .output_press_run       (pr),
    .output_press_step      (ps)
  );

  // Expected pulse cycle, kept sorted by cycle; pulses landing in one cycle merge.
  function automatic void expect_event(input int c, input logic t, input logic r,
                                       input logic p_r, input logic p_s);
    int  i;
    ev_t e;
    i = 0;
    while (i < sb.size() && sb[i].cyc < c) i++;
    if (i < sb.size() && sb[i].cyc == c) begin
      e      = sb[i];
      e.tick = e.tick | t;
      e.pr   = e.pr | p_r;
      e.ps   = e.ps | p_s;
      e.run  = r;
      sb[i]  = e;
    end else begin
      e.cyc  = c;
      e.tick = t;
      e.run  = r;
      e.pr   = p_r;
      e.ps   = p_s;
      sb.insert(i, e);
    end
  endfunction

  function automatic void expect_ticks(input int first, input int stop_excl);
    for (int c = first; c < stop_excl; c += DIV) expect_event(c, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic void expect_level(input int c, input logic t, input logic r,
                                       input logic p_r, input logic p_s);
    ev_t e;
    e.cyc  = c;
    e.tick = t;
    e.run  = r;
    e.pr   = p_r;
    e.ps   = p_s;
    lq.push_back(e);
  endfunction

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: samples on the falling edge, cycle number = last rising edge count.
  ev_t m;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      m = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_event cycle %0d: required tick=%0b run=%0b press_run=%0b press_step=%0b, saw no pulse",
               m.cyc, m.tick, m.run, m.pr, m.ps);
    end
    while (lq.size() > 0 && lq[0].cyc < cyc) begin
      m = lq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_level_check cycle %0d", m.cyc);
    end
    if (lq.size() > 0 && lq[0].cyc == cyc) begin
      m = lq.pop_front();
      n_tests++;
      if ({tick, run, pr, ps} !== {m.tick, m.run, m.pr, m.ps}) begin
        n_fail++;
        $display("FAIL level cycle %0d: got tick=%0b run=%0b press_run=%0b press_step=%0b, required %0b %0b %0b %0b",
                 cyc, tick, run, pr, ps, m.tick, m.run, m.pr, m.ps);
      end
    end
    if (tick === 1'b1 || pr === 1'b1 || ps === 1'b1) begin
      n_tests++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        n_fail++;
        $display("FAIL unexpected_event cycle %0d: got tick=%0b run=%0b press_run=%0b press_step=%0b, required no pulse",
                 cyc, tick, run, pr, ps);
      end else begin
        m = sb.pop_front();
        if ({tick, run, pr, ps} !== {m.tick, m.run, m.pr, m.ps}) begin
          n_fail++;
          $display("FAIL event cycle %0d: got tick=%0b run=%0b press_run=%0b press_step=%0b, required %0b %0b %0b %0b",
                   cyc, tick, run, pr, ps, m.tick, m.run, m.pr, m.ps);
        end
      end
    end
    if (done) begin
      n_tests++;
      if (sb.size() != 0 || lq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: got %0d events and %0d level checks pending, required 0", sb.size(), lq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    if (cyc > 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: got cycle %0d, required finish before 3000", cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  int b, q, u, v, x;

  initial begin
    // Reset held for three edges, then idle.
    step_to(3);
    rst = 1'b0;
    expect_level(3, 1'b0, 1'b0, 1'b0, 1'b0);
    step_to(53);
    expect_level(53, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press: start running, then stop with prescaler at 2.
    b = cyc;
    btn_run = 1'b1;
    expect_event(b + LAT + 1, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_ticks(b + 14, b + 50);
    step_to(b + 20);
    btn_run = 1'b0;
    step_to(b + 39);
    btn_run = 1'b1;
    expect_event(b + 50, 1'b0, 1'b0, 1'b1, 1'b0);
    step_to(b + 54);
    btn_run = 1'b0;
    step_to(b + 70);
    expect_level(b + 70, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bouncing press and release, step while running, then stop.
    q = cyc;
    expect_event(q + 16, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_ticks(q + 19, q + 71);
    for (int i = 0; i < 5; i++) begin
      step_to(q + i);
      btn_run = (bounce_on[i] != 0);
    end
    step_to(q + 5);
    btn_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_to(q + 20 + i);
      btn_run = (bounce_off[i] != 0);
    end
    step_to(q + 25);
    btn_run = 1'b0;
    step_to(q + 30);
    expect_level(q + 30, 1'b0, 1'b1, 1'b0, 1'b0);
    step_to(q + 41);
    btn_step = 1'b1;
    expect_event(q + 52, 1'b0, 1'b1, 1'b0, 1'b1);
    step_to(q + 55);
    btn_step = 1'b0;
    step_to(q + 60);
    btn_run = 1'b1;
    expect_event(q + 71, 1'b0, 1'b0, 1'b1, 1'b0);
    step_to(q + 75);
    btn_run = 1'b0;

    // Single step while stopped.
    step_to(q + 85);
    u = cyc;
    btn_step = 1'b1;
    expect_event(u + 11, 1'b1, 1'b0, 1'b0, 1'b1);
    step_to(u + 15);
    btn_step = 1'b0;
    step_to(u + 35);
    expect_level(u + 35, 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous run and step acceptance, both directions.
    v = cyc;
    btn_run  = 1'b1;
    btn_step = 1'b1;
    expect_event(v + 11, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_ticks(v + 14, v + 51);
    step_to(v + 20);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    step_to(v + 40);
    btn_run  = 1'b1;
    btn_step = 1'b1;
    expect_event(v + 51, 1'b1, 1'b0, 1'b1, 1'b1);
    step_to(v + 55);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    step_to(v + 75);
    expect_level(v + 75, 1'b0, 1'b0, 1'b0, 1'b0);

    // Both held: one press each, then reset with prescaler at 3 while held.
    x = cyc;
    btn_run  = 1'b1;
    btn_step = 1'b1;
    expect_event(x + 11, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_ticks(x + 14, x + 55);
    step_to(x + 54);
    rst = 1'b1;
    step_to(x + 55);
    rst = 1'b0;
    expect_level(x + 55, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_event(x + 66, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_ticks(x + 69, x + 91);
    step_to(x + 90);
    rst = 1'b1;
    step_to(x + 93);
    expect_level(x + 93, 1'b0, 1'b0, 1'b0, 1'b0);
    done = 1'b1;
  end

endmodule
